// File: rtl/laser_detect_multi.sv
// ---------------------------------------------------------------------------
// laser_detect_multi
//
// Multi-channel debounced laser tripwire detector. Each channel classifies
// its light-sensor sample against a "beam present" window
// [THRESH_LO, THRESH_HI]. A channel trips only after DEBOUNCE consecutive
// out-of-window samples. It clears only after DEBOUNCE consecutive in-window
// samples.
//
// Optional feature (macro LASER_TRIP_COUNT_EN): per-channel saturating trip
// counters on trip_count, zeroed by count_clear.
//
// Ports:
//   clk             system clock
//   rst             asynchronous active-high reset
//   sample_valid    all channels carry a new sample this cycle
//   light_sensor    packed samples, channel i at [i*SAMPLE_W +: SAMPLE_W]
//   alarm_clear     per-channel clear of alarm_latched
//   count_clear     (LASER_TRIP_COUNT_EN only) zero all trip counters
//   trip_count      (LASER_TRIP_COUNT_EN only) NUM_CH x CNT_W trip counters
//   laser_triggered debounced live status, 1 = beam broken
//   trip_event      one-cycle pulse on each debounced trip
//   alarm_latched   sticky trip indication
//   any_triggered   OR of laser_triggered
// ---------------------------------------------------------------------------
module laser_detect_multi #(
    parameter int NUM_CH    = 4,
    parameter int SAMPLE_W  = 13,
    parameter int THRESH_LO = 4000,
    parameter int THRESH_HI = 4999,
    parameter int DEBOUNCE  = 3,
    parameter int CNT_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0] light_sensor,
    input  logic [NUM_CH-1:0]          alarm_clear,
`ifdef LASER_TRIP_COUNT_EN
    input  logic                       count_clear,
    output logic [NUM_CH*CNT_W-1:0]    trip_count,
`endif
    output logic [NUM_CH-1:0]          laser_triggered,
    output logic [NUM_CH-1:0]          trip_event,
    output logic [NUM_CH-1:0]          alarm_latched,
    output logic                       any_triggered
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PEND_TRIP = 2'd1,
        S_TRIPPED   = 2'd2,
        S_PEND_CLR  = 2'd3
    } state_t;

    localparam logic [7:0]          DB = 8'(DEBOUNCE);
    localparam logic [SAMPLE_W-1:0] LO = SAMPLE_W'(THRESH_LO);
    localparam logic [SAMPLE_W-1:0] HI = SAMPLE_W'(THRESH_HI);

    // Elaboration-time guard against out-of-range configuration.
    if ((NUM_CH < 1) || (NUM_CH > 16) || (DEBOUNCE < 1) || (DEBOUNCE > 255) || (CNT_W < 1)) begin : g_bad_param
        $error("laser_detect_multi: parameter out of range");
    end

    // Next-state "beam broken" per channel, used for the registered summary.
    logic [NUM_CH-1:0] trig_next;
    logic              any_reg;

    genvar gi;
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
        state_t              state_reg, state_next;
        logic [7:0]          cnt_reg, cnt_next, cnt_inc;
        logic                trip_next;
        logic                triggered_reg, trip_reg, alarm_reg;
        logic [SAMPLE_W-1:0] sample;
        logic                in_win;

        assign sample  = light_sensor[gi*SAMPLE_W +: SAMPLE_W];
        assign in_win  = (sample >= LO) && (sample <= HI);
        assign cnt_inc = cnt_reg + 8'd1;

        always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            trip_next  = 1'b0;
            if (sample_valid) begin
                case (state_reg)
                    S_IDLE: begin
                        if (!in_win) begin
                            cnt_next = 8'd1;
                            if (DB == 8'd1) begin
                                state_next = S_TRIPPED;
                                trip_next  = 1'b1;
                            end else begin
                                state_next = S_PEND_TRIP;
                            end
                        end else begin
                            cnt_next = 8'd0;
                        end
                    end
                    S_PEND_TRIP: begin
                        if (!in_win) begin
                            cnt_next = cnt_inc;
                            if (cnt_inc >= DB) begin
                                state_next = S_TRIPPED;
                                trip_next  = 1'b1;
                            end
                        end else begin
                            state_next = S_IDLE;
                            cnt_next   = 8'd0;
                        end
                    end
                    S_TRIPPED: begin
                        if (in_win) begin
                            cnt_next   = 8'd1;
                            state_next = (DB == 8'd1) ? S_IDLE : S_PEND_CLR;
                        end else begin
                            cnt_next = 8'd0;
                        end
                    end
                    S_PEND_CLR: begin
                        if (in_win) begin
                            cnt_next = cnt_inc;
                            if (cnt_inc >= DB) begin
                                state_next = S_IDLE;
                            end
                        end else begin
                            // Falling back to TRIPPED is not a new trip: no pulse.
                            state_next = S_TRIPPED;
                            cnt_next   = 8'd0;
                        end
                    end
                    default: begin
                        state_next = S_IDLE;
                        cnt_next   = 8'd0;
                    end
                endcase
            end
        end

        assign trig_next[gi] = (state_next == S_TRIPPED) || (state_next == S_PEND_CLR);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_reg     <= S_IDLE;
                cnt_reg       <= 8'd0;
                triggered_reg <= 1'b0;
                trip_reg      <= 1'b0;
                alarm_reg     <= 1'b0;
            end else begin
                state_reg     <= state_next;
                cnt_reg       <= cnt_next;
                triggered_reg <= trig_next[gi];
                trip_reg      <= trip_next;
                // A trip in the same cycle as a clear takes priority.
                if (trip_next) begin
                    alarm_reg <= 1'b1;
                end else if (alarm_clear[gi]) begin
                    alarm_reg <= 1'b0;
                end
            end
        end

        assign laser_triggered[gi] = triggered_reg;
        assign trip_event[gi]      = trip_reg;
        assign alarm_latched[gi]   = alarm_reg;

`ifdef LASER_TRIP_COUNT_EN
        logic [CNT_W-1:0] count_reg;

        // Counts on the same edge that raises trip_event; clear wins.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                count_reg <= '0;
            end else if (count_clear) begin
                count_reg <= '0;
            end else if (trip_next && (count_reg != {CNT_W{1'b1}})) begin
                count_reg <= count_reg + 1'b1;
            end
        end

        assign trip_count[gi*CNT_W +: CNT_W] = count_reg;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_reg <= 1'b0;
        end else begin
            any_reg <= |trig_next;
        end
    end

    assign any_triggered = any_reg;

endmodule

// File: tb/tb_laser_detect_multi.sv
// ---------------------------------------------------------------------------
// tb_laser_detect_multi
//
// Directed-vector bench for laser_detect_multi (NUM_CH=4, DEBOUNCE=3,
// window 4000..4999, CNT_W=2). Expected values are hand-computed constants.
// The counter checks are compiled when LASER_TRIP_COUNT_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_laser_detect_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [51:0] light_sensor;
    logic [3:0]  alarm_clear;
    logic [3:0]  laser_triggered;
    logic [3:0]  trip_event;
    logic [3:0]  alarm_latched;
    logic        any_triggered;
`ifdef LASER_TRIP_COUNT_EN
    logic        count_clear;
    logic [7:0]  trip_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [12:0] smp [4];

    laser_detect_multi #(
        .NUM_CH(4), .SAMPLE_W(13), .THRESH_LO(4000), .THRESH_HI(4999),
        .DEBOUNCE(3), .CNT_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_valid(sample_valid),
        .light_sensor(light_sensor),
        .alarm_clear(alarm_clear),
`ifdef LASER_TRIP_COUNT_EN
        .count_clear(count_clear),
        .trip_count(trip_count),
`endif
        .laser_triggered(laser_triggered),
        .trip_event(trip_event),
        .alarm_latched(alarm_latched),
        .any_triggered(any_triggered)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Present the current sample set for one clock; outputs are sampled 1ns after the edge.
    task automatic step(input logic v);
        light_sensor = {smp[3], smp[2], smp[1], smp[0]};
        sample_valid = v;
        @(posedge clk);
        #1;
    endtask

    // n valid samples of val on channel ch, then channel returns to 4500.
    task automatic run(input int ch, input logic [12:0] val, input int n);
        smp[ch] = val;
        repeat (n) step(1'b1);
        smp[ch] = 13'd4500;
    endtask

    initial begin
        bit quiet_ok;
        for (int i = 0; i < 4; i++) smp[i] = 13'd4500;
        rst = 1'b1;
        sample_valid = 1'b0;
        alarm_clear = 4'h0;
        light_sensor = '0;
`ifdef LASER_TRIP_COUNT_EN
        count_clear = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_lt", 32'(laser_triggered), 32'h0);
        check("reset_al", 32'(alarm_latched), 32'h0);
        check("reset_any", 32'(any_triggered), 32'h0);
        rst = 1'b0;

        // 1: all in-window for 20 valid cycles
        quiet_ok = 1'b1;
        repeat (20) begin
            step(1'b1);
            if ((laser_triggered | trip_event | alarm_latched) != 4'h0 || any_triggered) quiet_ok = 1'b0;
        end
        check("quiet_20", 32'(quiet_ok), 32'h1);

        // 2: ch1 broken x3
        smp[1] = 13'd3000;
        step(1'b1); step(1'b1);
        check("t2_pre_lt", 32'(laser_triggered), 32'h0);
        step(1'b1);
        check("t2_lt", 32'(laser_triggered), 32'h2);
        check("t2_te", 32'(trip_event), 32'h2);
        check("t2_al", 32'(alarm_latched), 32'h2);
        check("t2_any", 32'(any_triggered), 32'h1);
        step(1'b1);
        check("t2_te_once", 32'(trip_event), 32'h0);
        check("t2_lt_hold", 32'(laser_triggered), 32'h2);
        run(1, 13'd4500, 3);
        check("t2_clr_lt", 32'(laser_triggered), 32'h0);
        check("t2_clr_any", 32'(any_triggered), 32'h0);
        check("t2_al_sticky", 32'(alarm_latched), 32'h2);
        alarm_clear = 4'h2; step(1'b1); alarm_clear = 4'h0;
        check("t2_al_cleared", 32'(alarm_latched), 32'h0);

        // 3: ch0 count restarts on an in-window sample
        run(0, 13'd3000, 2);
        run(0, 13'd4500, 1);
        run(0, 13'd3000, 2);
        check("t3_restart", 32'(laser_triggered), 32'h0);
        run(0, 13'd3000, 1);
        check("t3_trip", 32'(laser_triggered), 32'h1);
        check("t3_te", 32'(trip_event), 32'h1);
        run(0, 13'd4500, 3);
        alarm_clear = 4'h1; step(1'b1); alarm_clear = 4'h0;
        check("t3_cleared", 32'(laser_triggered | alarm_latched), 32'h0);

        // 4: ch2 partial clear aborted, then real clear
        run(2, 13'd3000, 3);
        check("t4_trip", 32'(laser_triggered), 32'h4);
        run(2, 13'd4200, 2);
        check("t4_pendclr_lt", 32'(laser_triggered), 32'h4);
        run(2, 13'd5200, 1);
        check("t4_back_lt", 32'(laser_triggered), 32'h4);
        check("t4_back_no_te", 32'(trip_event), 32'h0);
        run(2, 13'd4200, 2);
        check("t4_two_in_lt", 32'(laser_triggered), 32'h4);
        run(2, 13'd4200, 1);
        check("t4_fall_lt", 32'(laser_triggered), 32'h0);
        check("t4_al_held", 32'(alarm_latched), 32'h4);
        alarm_clear = 4'h4; step(1'b1); alarm_clear = 4'h0;
        check("t4_al_cleared", 32'(alarm_latched), 32'h0);

        // 5: boundary values on ch3
        run(3, 13'd4000, 3);
        check("t5_4000", 32'(laser_triggered), 32'h0);
        run(3, 13'd4999, 3);
        check("t5_4999", 32'(laser_triggered), 32'h0);
        run(3, 13'd3999, 3);
        check("t5_3999", 32'(laser_triggered), 32'h8);
        run(3, 13'd4500, 3);
        check("t5_3999_clr", 32'(laser_triggered), 32'h0);
        run(3, 13'd5000, 3);
        check("t5_5000", 32'(laser_triggered), 32'h8);
        run(3, 13'd4500, 3);
        check("t5_5000_clr", 32'(laser_triggered), 32'h0);
        // Invalid cycles carry an in-window value that must be ignored.
        smp[3] = 13'd5000; step(1'b1);
        smp[3] = 13'd4500; step(1'b0);
        check("t5_gap1", 32'(laser_triggered), 32'h0);
        smp[3] = 13'd5000; step(1'b1);
        smp[3] = 13'd4500; step(1'b0); step(1'b0);
        check("t5_gap2", 32'(laser_triggered), 32'h0);
        smp[3] = 13'd5000; step(1'b1);
        check("t5_gap_trip", 32'(laser_triggered), 32'h8);
        check("t5_gap_te", 32'(trip_event), 32'h8);
        smp[3] = 13'd4500; step(1'b0);
        check("t5_invalid_te", 32'(trip_event), 32'h0);
        check("t5_invalid_lt", 32'(laser_triggered), 32'h8);
        run(3, 13'd4500, 3);
        alarm_clear = 4'hF; step(1'b1); alarm_clear = 4'h0;
        check("t5_all_clear", 32'(laser_triggered | alarm_latched), 32'h0);

        // Trip coincident with alarm_clear: set wins
        smp[0] = 13'd3000;
        step(1'b1); step(1'b1);
        alarm_clear = 4'h1; step(1'b1); alarm_clear = 4'h0;
        check("set_wins_al", 32'(alarm_latched), 32'h1);
        check("set_wins_te", 32'(trip_event), 32'h1);
        // Simultaneous trips on ch1 and ch2 while ch0 stays tripped
        smp[1] = 13'd3000; smp[2] = 13'd3000;
        repeat (3) step(1'b1);
        check("simul_lt", 32'(laser_triggered), 32'h7);
        check("simul_te", 32'(trip_event), 32'h6);
        smp[0] = 13'd4500; smp[1] = 13'd4500; smp[2] = 13'd4500;

        // Reset mid-debounce: asynchronous clear, partial count discarded
        smp[3] = 13'd3000;
        step(1'b1); step(1'b1);
        rst = 1'b1;
        #1;
        check("async_rst_lt", 32'(laser_triggered), 32'h0);
        check("async_rst_al", 32'(alarm_latched), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(1'b1);
        check("rst_partial_lt", 32'(laser_triggered), 32'h0);
        step(1'b1);
        check("rst_partial_lt2", 32'(laser_triggered), 32'h0);
        step(1'b1);
        check("rst_full_lt", 32'(laser_triggered), 32'h8);
        smp[3] = 13'd4500;

`ifdef LASER_TRIP_COUNT_EN
        // 6: saturating counters (CNT_W=2)
        count_clear = 1'b1; step(1'b1); count_clear = 1'b0;
        check("cnt_cleared", 32'(trip_count[1:0]), 32'h0);
        for (int k = 1; k <= 5; k++) begin
            run(0, 13'd3000, 3);
            if (k == 1) check("cnt_1", 32'(trip_count[1:0]), 32'h1);
            if (k == 3) check("cnt_3", 32'(trip_count[1:0]), 32'h3);
            run(0, 13'd4500, 3);
        end
        check("cnt_sat", 32'(trip_count[1:0]), 32'h3);
        smp[0] = 13'd3000;
        step(1'b1); step(1'b1);
        count_clear = 1'b1; step(1'b1); count_clear = 1'b0;
        check("cnt_clr_wins", 32'(trip_count[1:0]), 32'h0);
        check("cnt_clr_te", 32'(trip_event[0]), 32'h1);
        smp[0] = 13'd4500;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
